// File: rtl/cpu_pkg.sv
// Shared types and select codes for the simple CPU controller.
//   op_t    : instruction opcodes (IR[15:12])
//   state_t : controller FSM states
//   ALU_*   : alu_s1/alu_s0 select codes
//   WSEL_*  : RF_s1/RF_s0 register-file write-mux select codes
package cpu_pkg;

  typedef enum logic [3:0] {
    OpLoad  = 4'h0,
    OpStore = 4'h1,
    OpAdd   = 4'h2,
    OpLoadc = 4'h3,
    OpSub   = 4'h4,
    OpJmpz  = 4'h5,
    OpAbs   = 4'h6,
    OpHalt  = 4'hF
  } op_t;

  typedef enum logic [3:0] {
    StInit,
    StFetch,
    StDecode,
    StLoad,
    StStore,
    StAdd,
    StLoadc,
    StSub,
    StJmpz,
    StAbs,
    StHalt
  } state_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  localparam logic [1:0] WSEL_ALU   = 2'b00;
  localparam logic [1:0] WSEL_DM    = 2'b01;
  localparam logic [1:0] WSEL_CONST = 2'b10;
  localparam logic [1:0] WSEL_ABS   = 2'b11;

endpackage

// File: rtl/pc_unit.sv
// Program counter register.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (PC <= 0)
//   clr_i    : clear PC to 0
//   inc_i    : PC <= PC + 1
//   load_i   : PC <= PC + sext(offset_i) - 1 (PC already points past the branch)
//   offset_i : 8-bit signed branch offset
//   pc_o     : current PC
// Priority: clear, then load, then increment. Arithmetic wraps modulo 2^PcW.
// PcW must be wider than 8.
module pc_unit #(
  parameter int unsigned PcW = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           inc_i,
  input  logic           load_i,
  input  logic [7:0]     offset_i,
  output logic [PcW-1:0] pc_o
);

  logic [PcW-1:0] pc_q, pc_d;
  logic [PcW-1:0] offset_ext;

  assign offset_ext = {{(PcW-8){offset_i[7]}}, offset_i};

  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (load_i) begin
      pc_d = pc_q + offset_ext - PcW'(1);
    end else if (inc_i) begin
      pc_d = pc_q + PcW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle controller for the simple register-file/ALU CPU.
// Sequences FETCH -> DECODE -> execute for each 16-bit instruction and drives all datapath,
// instruction-memory and data-memory control lines as Moore outputs of state and IR.
//   clk, rst            : clock, synchronous active-high reset
//   I_data/I_addr/I_rd  : instruction memory read port (I_addr = PC)
//   D_addr/D_rd/D_wr    : data memory address and strobes
//   RF_W_data           : LOADC constant
//   RF_s1/RF_s0         : write-mux select (ALU, DM, constant, abs)
//   RF_*_addr, RF_*_rd/wr : register-file addresses and enables
//   alu_s1/alu_s0       : ALU select
//   RF_Rp_zero          : Rp_data == 0, used by JMPZ
//   halted, illegal     : HALT state; sticky undefined-opcode flag
// All outputs are forced to 0 while rst is high so a reset mid-execute suppresses writes.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     I_data,
  output logic [PC_W-1:0] I_addr,
  output logic            I_rd,
  output logic [7:0]      D_addr,
  output logic            D_rd,
  output logic            D_wr,
  output logic [7:0]      RF_W_data,
  output logic            RF_s1,
  output logic            RF_s0,
  output logic [3:0]      RF_W_addr,
  output logic [3:0]      RF_Rp_addr,
  output logic [3:0]      RF_Rq_addr,
  output logic            RF_W_wr,
  output logic            RF_Rp_rd,
  output logic            RF_Rq_rd,
  output logic            alu_s1,
  output logic            alu_s0,
  input  logic            RF_Rp_zero,
  output logic            halted,
  output logic            illegal
);

  state_t          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;
  logic            pc_clr, pc_inc, pc_load;
  logic [PC_W-1:0] pc;
  logic [1:0]      wsel, alu_sel;

  logic [3:0] ir_op, ir_a, ir_b, ir_c;
  logic [7:0] ir_k;

  assign ir_op = ir_q[15:12];
  assign ir_a  = ir_q[11:8];
  assign ir_b  = ir_q[7:4];
  assign ir_c  = ir_q[3:0];
  assign ir_k  = ir_q[7:0];

  pc_unit #(
    .PcW(PC_W)
  ) u_pc (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (pc_clr),
    .inc_i   (pc_inc),
    .load_i  (pc_load),
    .offset_i(ir_k),
    .pc_o    (pc)
  );

  // Next state, IR, sticky illegal flag and PC control.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    unique case (state_q)
      StInit: begin
        state_d = StFetch;
        ir_d    = '0;
        pc_clr  = 1'b1;
      end
      StFetch: begin
        ir_d    = I_data;
        pc_inc  = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        case (ir_op)
          OpLoad:  state_d = StLoad;
          OpStore: state_d = StStore;
          OpAdd:   state_d = StAdd;
          OpLoadc: state_d = StLoadc;
          OpSub:   state_d = StSub;
          OpJmpz:  state_d = StJmpz;
          OpAbs:   state_d = StAbs;
          OpHalt:  state_d = StHalt;
          default: begin
            // Undefined opcode behaves as a two-cycle NOP.
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StJmpz: begin
        pc_load = RF_Rp_zero;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore-decoded outputs; everything not listed for a state stays 0.
  always_comb begin
    I_addr     = '0;
    I_rd       = 1'b0;
    D_addr     = '0;
    D_rd       = 1'b0;
    D_wr       = 1'b0;
    RF_W_data  = '0;
    wsel       = WSEL_ALU;
    RF_W_addr  = '0;
    RF_Rp_addr = '0;
    RF_Rq_addr = '0;
    RF_W_wr    = 1'b0;
    RF_Rp_rd   = 1'b0;
    RF_Rq_rd   = 1'b0;
    alu_sel    = ALU_ADD;
    halted     = 1'b0;
    if (!rst) begin
      if (state_q != StInit) begin
        I_addr = pc;
      end
      unique case (state_q)
        StFetch: I_rd = 1'b1;
        StLoad: begin
          D_addr    = ir_k;
          D_rd      = 1'b1;
          wsel      = WSEL_DM;
          RF_W_addr = ir_a;
          RF_W_wr   = 1'b1;
        end
        StStore: begin
          D_addr     = ir_k;
          D_wr       = 1'b1;
          RF_Rp_addr = ir_a;
          RF_Rp_rd   = 1'b1;
        end
        StAdd, StSub: begin
          RF_Rp_addr = ir_b;
          RF_Rq_addr = ir_c;
          RF_Rp_rd   = 1'b1;
          RF_Rq_rd   = 1'b1;
          alu_sel    = (state_q == StSub) ? ALU_SUB : ALU_ADD;
          wsel       = WSEL_ALU;
          RF_W_addr  = ir_a;
          RF_W_wr    = 1'b1;
        end
        StLoadc: begin
          RF_W_data = ir_k;
          wsel      = WSEL_CONST;
          RF_W_addr = ir_a;
          RF_W_wr   = 1'b1;
        end
        StAbs: begin
          RF_Rp_addr = ir_b;
          RF_Rp_rd   = 1'b1;
          wsel       = WSEL_ABS;
          RF_W_addr  = ir_a;
          RF_W_wr    = 1'b1;
        end
        StJmpz: begin
          RF_Rp_addr = ir_a;
          RF_Rp_rd   = 1'b1;
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign RF_s1   = wsel[1];
  assign RF_s0   = wsel[0];
  assign alu_s1  = alu_sel[1];
  assign alu_s0  = alu_sel[0];
  assign illegal = illegal_q & ~rst;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: a small datapath/memory environment driven by the DUT, and an
// instruction-level reference model that predicts every control output each cycle.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        env_clr = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] I_data, I_addr;
  logic        I_rd, D_rd, D_wr, RF_s1, RF_s0, RF_W_wr, RF_Rp_rd, RF_Rq_rd;
  logic        alu_s1, alu_s0, RF_Rp_zero, halted, illegal;
  logic [7:0]  D_addr, RF_W_data;
  logic [3:0]  RF_W_addr, RF_Rp_addr, RF_Rq_addr;

  cpu_controller #(.PC_W(16)) dut (
    .clk(clk), .rst(rst), .I_data(I_data), .I_addr(I_addr), .I_rd(I_rd),
    .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .RF_W_data(RF_W_data),
    .RF_s1(RF_s1), .RF_s0(RF_s0), .RF_W_addr(RF_W_addr), .RF_Rp_addr(RF_Rp_addr),
    .RF_Rq_addr(RF_Rq_addr), .RF_W_wr(RF_W_wr), .RF_Rp_rd(RF_Rp_rd), .RF_Rq_rd(RF_Rq_rd),
    .alu_s1(alu_s1), .alu_s0(alu_s0), .RF_Rp_zero(RF_Rp_zero), .halted(halted),
    .illegal(illegal)
  );

  // ---------------- environment: memories and datapath ----------------
  logic [15:0] imem    [65536];
  logic [15:0] dm_init [256];
  logic [15:0] env_rf  [16];
  logic [15:0] env_dm  [256];
  logic [15:0] env_rp, env_rq, env_alu, env_wv;

  assign I_data     = imem[I_addr];
  assign env_rp     = env_rf[RF_Rp_addr];
  assign env_rq     = env_rf[RF_Rq_addr];
  assign RF_Rp_zero = (env_rp == 16'h0000);

  always_comb begin
    env_alu = env_rp;
    case ({alu_s1, alu_s0})
      2'b00:   env_alu = env_rp + env_rq;
      2'b01:   env_alu = env_rp - env_rq;
      default: env_alu = env_rp;
    endcase
    env_wv = env_alu;
    case ({RF_s1, RF_s0})
      2'b00:   env_wv = env_alu;
      2'b01:   env_wv = env_dm[D_addr];
      2'b10:   env_wv = {8'h00, RF_W_data};
      default: env_wv = env_rp[15] ? (16'h0000 - env_rp) : env_rp;
    endcase
  end

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 16; i++) env_rf[i] <= '0;
      for (int i = 0; i < 256; i++) env_dm[i] <= dm_init[i];
    end else begin
      if (RF_W_wr) env_rf[RF_W_addr] <= env_wv;
      if (D_wr) env_dm[D_addr] <= env_rp;
    end
  end

  // ---------------- reference model: instruction-level CPU ----------------
  typedef enum int {MInit, MFetch, MDecode, MExec, MHalt} mphase_t;
  mphase_t     m_phase = MInit;
  logic [15:0] m_pc, m_ir;
  logic        m_ill;
  logic [15:0] m_rf [16];
  logic [15:0] m_dm [256];
  logic [3:0]  m_a, m_b, m_c;
  logic [7:0]  m_k;
  assign m_a = m_ir[11:8];
  assign m_b = m_ir[7:4];
  assign m_c = m_ir[3:0];
  assign m_k = m_ir[7:0];

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 16; i++) m_rf[i] <= '0;
      for (int i = 0; i < 256; i++) m_dm[i] <= dm_init[i];
    end
    if (rst) begin
      m_phase <= MInit;
      m_pc    <= '0;
      m_ir    <= '0;
      m_ill   <= 1'b0;
    end else begin
      case (m_phase)
        MInit: begin
          m_phase <= MFetch;
          m_pc    <= '0;
          m_ir    <= '0;
        end
        MFetch: begin
          m_ir    <= imem[m_pc];
          m_pc    <= m_pc + 16'd1;
          m_phase <= MDecode;
        end
        MDecode: begin
          if (m_ir[15:12] <= 4'd6) m_phase <= MExec;
          else if (m_ir[15:12] == 4'hF) m_phase <= MHalt;
          else begin
            m_ill   <= 1'b1;
            m_phase <= MFetch;
          end
        end
        MExec: begin
          m_phase <= MFetch;
          case (m_ir[15:12])
            4'h0: m_rf[m_a] <= m_dm[m_k];
            4'h1: m_dm[m_k] <= m_rf[m_a];
            4'h2: m_rf[m_a] <= m_rf[m_b] + m_rf[m_c];
            4'h3: m_rf[m_a] <= {8'h00, m_k};
            4'h4: m_rf[m_a] <= m_rf[m_b] - m_rf[m_c];
            4'h5: if (m_rf[m_a] == 16'h0) m_pc <= m_pc - 16'd1 + {{8{m_k[7]}}, m_k};
            default: m_rf[m_a] <= m_rf[m_b][15] ? (16'h0000 - m_rf[m_b]) : m_rf[m_b];
          endcase
        end
        default: ;
      endcase
    end
  end

  typedef struct packed {
    logic [15:0] i_addr; logic i_rd; logic [7:0] d_addr; logic d_rd; logic d_wr;
    logic [7:0] w_data; logic [1:0] wsel; logic [3:0] w_addr; logic [3:0] rp_addr;
    logic [3:0] rq_addr; logic w_wr; logic rp_rd; logic rq_rd; logic [1:0] alu;
    logic halted; logic ill;
  } ctl_t;

  ctl_t act, exp_c;
  assign act = {I_addr, I_rd, D_addr, D_rd, D_wr, RF_W_data, RF_s1, RF_s0, RF_W_addr,
                RF_Rp_addr, RF_Rq_addr, RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_s1, alu_s0,
                halted, illegal};

  function automatic ctl_t expect_ctl(mphase_t ph, logic [15:0] ir, logic [15:0] pc,
                                      logic ill, logic r);
    ctl_t e;
    e = '0;
    if (r) return e;
    e.ill = ill;
    if (ph != MInit) e.i_addr = pc;
    case (ph)
      MFetch: e.i_rd = 1'b1;
      MHalt:  e.halted = 1'b1;
      MExec: begin
        case (ir[15:12])
          4'h0: begin e.d_addr = ir[7:0]; e.d_rd = 1'b1; e.wsel = 2'b01;
                      e.w_addr = ir[11:8]; e.w_wr = 1'b1; end
          4'h1: begin e.d_addr = ir[7:0]; e.d_wr = 1'b1; e.rp_addr = ir[11:8];
                      e.rp_rd = 1'b1; end
          4'h2, 4'h4: begin
            e.rp_addr = ir[7:4]; e.rq_addr = ir[3:0]; e.rp_rd = 1'b1; e.rq_rd = 1'b1;
            e.alu = (ir[15:12] == 4'h4) ? 2'b01 : 2'b00;
            e.w_addr = ir[11:8]; e.w_wr = 1'b1;
          end
          4'h3: begin e.w_data = ir[7:0]; e.wsel = 2'b10; e.w_addr = ir[11:8];
                      e.w_wr = 1'b1; end
          4'h5: begin e.rp_addr = ir[11:8]; e.rp_rd = 1'b1; end
          default: begin e.rp_addr = ir[7:4]; e.rp_rd = 1'b1; e.wsel = 2'b11;
                         e.w_addr = ir[11:8]; e.w_wr = 1'b1; end
        endcase
      end
      default: ;
    endcase
    return e;
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hc;
  logic [15:0] fetch_q[$];
  int          fetch_cyc[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t cyc=%0d got %h want %h", name, $time, cyc, got, want);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (I_rd) begin
      fetch_q.push_back(I_addr);
      fetch_cyc.push_back(cyc);
    end
    exp_c = expect_ctl(m_phase, m_ir, m_pc, m_ill, rst);
    check("ctl", 64'(act), 64'(exp_c));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    env_clr = 1'b1;
    step();
    rst = 1'b0;
    env_clr = 1'b0;
    cyc = 0;
    fetch_q.delete();
    fetch_cyc.delete();
  endtask

  task automatic run_until_halt(input int budget, output int hcyc);
    hcyc = -1;
    while (!halted && cyc < budget) step();
    if (halted) hcyc = cyc;
    check("halted", 64'(halted), 64'd1);
  endtask

  task automatic fill_imem();
    for (int i = 0; i < 65536; i++) imem[i] = 16'hF000;
    for (int i = 0; i < 256; i++) dm_init[i] = 16'h0000;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] a, b, c;
    int r;
    r = $urandom_range(0, 9);
    a = 4'($urandom_range(0, 3));
    b = 4'($urandom_range(0, 3));
    c = 4'($urandom_range(0, 3));
    case (r)
      0: return {4'h0, a, 8'($urandom_range(0, 7))};
      1: return {4'h1, a, 8'($urandom_range(0, 7))};
      2: return {4'h2, a, b, c};
      4: return {4'h4, a, b, c};
      5: return {4'h5, a, 8'($urandom_range(1, 3))};
      6: return {4'h6, a, b, 4'h0};
      7: return {4'($urandom_range(7, 14)), 12'($urandom)};
      9: return {4'h3, a, 8'h00};
      default: return {4'h3, a, 8'($urandom)};
    endcase
  endfunction

  initial begin
    // LOADC, LOADC, ADD, HALT
    fill_imem();
    imem[0] = 16'h3105; imem[1] = 16'h3207; imem[2] = 16'h2312;
    do_reset();
    check("init_iaddr", 64'(I_addr), 64'd0);
    run_until_halt(60, hc);
    check("add_halt_cycle", 64'(hc), 64'd12);
    check("add_rf3", 64'(env_rf[3]), 64'h000C);
    check("add_model_rf3", 64'(m_rf[3]), 64'h000C);

    // LOAD, LOAD, SUB, STORE
    fill_imem();
    dm_init[8'h10] = 16'h0009; dm_init[8'h11] = 16'h000C;
    imem[0] = 16'h0110; imem[1] = 16'h0211; imem[2] = 16'h4312; imem[3] = 16'h1312;
    do_reset();
    run_until_halt(60, hc);
    check("sub_dm12", 64'(env_dm[8'h12]), 64'hFFFD);
    check("sub_model_dm12", 64'(m_dm[8'h12]), 64'hFFFD);

    // ABS of a negative value
    fill_imem();
    imem[0] = 16'h31FF; imem[1] = 16'h4201; imem[2] = 16'h6320;
    do_reset();
    run_until_halt(60, hc);
    check("abs_rf3", 64'(env_rf[3]), 64'h00FF);

    // JMPZ taken backwards from addr 4 to addr 2
    fill_imem();
    for (int i = 0; i < 4; i++) imem[i] = 16'h3101;
    imem[4] = 16'h55FE;
    do_reset();
    for (int i = 0; i < 25; i++) step();
    check("jmpz_taken_pc", 64'(fetch_q[5]), 64'd2);
    check("jmpz_taken_lat", 64'(fetch_cyc[5] - fetch_cyc[4]), 64'd3);

    // JMPZ not taken
    imem[3] = 16'h3501;
    do_reset();
    run_until_halt(60, hc);
    check("jmpz_nt_pc", 64'(fetch_q[5]), 64'd5);
    check("jmpz_nt_lat", 64'(fetch_cyc[5] - fetch_cyc[4]), 64'd3);

    // Illegal opcode at 0xFFFF and PC wrap to 0
    fill_imem();
    imem[0] = 16'h5202; imem[2] = 16'h3201; imem[3] = 16'h50FC; imem[16'hFFFF] = 16'h7000;
    do_reset();
    run_until_halt(60, hc);
    check("wrap_fetch_ffff", 64'(fetch_q[3]), 64'hFFFF);
    check("wrap_fetch_0", 64'(fetch_q[4]), 64'h0000);
    check("nop_lat", 64'(fetch_cyc[4] - fetch_cyc[3]), 64'd2);
    check("illegal_sticky", 64'(illegal), 64'd1);
    check("wrap_halt_pc", 64'(fetch_q[5]), 64'd1);

    // Reset asserted during ADD suppresses the write
    fill_imem();
    imem[0] = 16'h3105; imem[1] = 16'h3207; imem[2] = 16'h2312;
    do_reset();
    while (cyc < 9) step();
    check("add_wr_before_rst", 64'(RF_W_wr), 64'd1);
    rst = 1'b1;
    step();
    check("rst_no_write", 64'(env_rf[3]), 64'h0000);
    check("rst_kept_r1", 64'(env_rf[1]), 64'h0005);
    check("rst_iaddr", 64'(I_addr), 64'd0);
    rst = 1'b0;
    cyc = 0;
    run_until_halt(60, hc);
    check("rerun_rf3", 64'(env_rf[3]), 64'h000C);

    // Random programs against the reference model
    for (int t = 0; t < 8; t++) begin
      fill_imem();
      for (int i = 0; i < 8; i++) dm_init[i] = 16'($urandom);
      for (int i = 0; i < 24; i++) imem[i] = rand_instr();
      do_reset();
      run_until_halt(200, hc);
      for (int r = 0; r < 16; r++) check("rnd_rf", 64'(env_rf[r]), 64'(m_rf[r]));
      for (int d = 0; d < 8; d++) check("rnd_dm", 64'(env_dm[d]), 64'(m_dm[d]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle FSM controller that sequences the register-file/ALU datapath of the simple CPU. It fetches 16-bit instructions from instruction memory, decodes them, and drives every datapath control line: register addresses, read and write enables, write-mux select, ALU select and constant. It also drives the data-memory strobes, and it implements conditional branching from the datapath's `RF_Rp_zero` flag. It sits between instruction memory, data memory and the datapath in the CPU top level.

## Interface
Parameters
- `PC_W`, default 16: program counter and `I_addr` width.

Ports
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `I_data` in 16: instruction word at `I_addr`; combinational read.
- `I_addr` out PC_W: instruction address (= PC).
- `I_rd` out 1: instruction read strobe.
- `D_addr` out 8: data-memory address.
- `D_rd` out 1: data-memory read; memory read is combinational onto datapath `DM_Din`.
- `D_wr` out 1: data-memory write of datapath `Rp_data`; write is synchronous.
- `RF_W_data` out 8: constant for LOADC.
- `RF_s1`, `RF_s0` out 1 each: write-mux select. 00 = ALU, 01 = DM_Din, 10 = constant, 11 = abs.
- `RF_W_addr`, `RF_Rp_addr`, `RF_Rq_addr` out 4 each: register addresses.
- `RF_W_wr`, `RF_Rp_rd`, `RF_Rq_rd` out 1 each: register-file enables.
- `alu_s1`, `alu_s0` out 1 each: ALU select. 00 = A+B, 01 = A−B, 10 = pass A.
- `RF_Rp_zero` in 1: Rp_data == 0 flag from the datapath.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky flag; set when an undefined opcode is decoded, cleared only by reset.

## Operation
Instruction encoding is op = IR[15:12], a = IR[11:8], b = IR[7:4], c = IR[3:0], k = IR[7:0].
- 0000 LOAD: RF[a] ← D[k].
- 0001 STORE: D[k] ← RF[a].
- 0010 ADD: RF[a] ← RF[b] + RF[c].
- 0011 LOADC: RF[a] ← k, zero-extended.
- 0100 SUB: RF[a] ← RF[b] − RF[c].
- 0101 JMPZ: if RF[a] == 0, PC ← addr(JMPZ) + sext(k).
- 0110 ABS: RF[a] ← |RF[b]|.
- 1111 HALT.
- Any other opcode: treated as a NOP and sets `illegal`.

States are INIT, FETCH, DECODE, LOAD, STORE, ADD, LOADC, SUB, JMPZ, ABS, HALT.
- INIT → FETCH: PC ← 0, IR ← 0.
- FETCH: `I_rd`=1; IR ← I_data; PC ← PC+1; next state DECODE.
- DECODE: all strobes 0; next state is the execute state selected by op; NOP goes to FETCH.
- LOAD: D_addr=k, D_rd=1, RF_s=01, W_addr=a, W_wr=1.
- STORE: D_addr=k, D_wr=1, Rp_addr=a, Rp_rd=1.
- ADD and SUB: Rp_addr=b, Rq_addr=c, both read enables 1, alu=00 (ADD) or 01 (SUB), RF_s=00, W_addr=a, W_wr=1.
- LOADC: RF_W_data=k, RF_s=10, W_addr=a, W_wr=1.
- ABS: Rp_addr=b, Rp_rd=1, RF_s=11, W_addr=a, W_wr=1.
- JMPZ: Rp_addr=a, Rp_rd=1; if RF_Rp_zero, PC ← PC + sext(k) − 1.
- Every execute state returns to FETCH.
- HALT holds with halted=1 and all strobes 0, until `rst`.

Arithmetic and boundaries:
- PC arithmetic is modulo 2^PC_W; 0xFFFF+1 wraps to 0.
- JMPZ with k=0x00 is a self-loop while RF[a]==0.
- Outputs are Moore-decoded from the state and IR. Every unused output in a state is 0.

## Timing
- Reset: after the reset edge, state=INIT, PC=0, IR=0, `illegal`=0.
- Output values in INIT and during reset: all outputs 0, `I_addr`=0, `halted`=0.
- `D_wr` and `RF_W_wr` are gated by ~rst, so a reset asserted mid-execute suppresses the write on that edge.
- Latency: 3 cycles per instruction (FETCH, DECODE, execute), including JMPZ taken or not; NOP takes 2. The first fetch is in the cycle after INIT.
- Register-file and memory writes commit on the clock edge that ends the execute state.
- JMPZ samples `RF_Rp_zero` combinationally in the JMPZ state.

## Structure
- `cpu_pkg` contains:
  - the opcode enum `op_t`;
  - the state enum `state_t`;
  - constants for the ALU select codes (ALU_ADD, ALU_SUB, ALU_PASS);
  - constants for the write-mux select codes (WSEL_ALU, WSEL_DM, WSEL_CONST, WSEL_ABS).
- One sub-module, `pc_unit`: PC register with clear, increment and signed-offset load.
- Top-level `cpu_top` instantiates `cpu_controller`, the datapath and both memories.

## Test plan
- Reset mid-run: assert `rst` during ADD → no RF write on that edge; next cycle all outputs 0 and PC=0.
- LOADC then ADD: program LOADC r1,0x05; LOADC r2,0x07; ADD r3,r1,r2; HALT → RF[3]=0x000C; `halted` rises in cycle 12.
- LOAD, SUB, STORE: D[0x10]=0x0009, D[0x11]=0x000C; LOAD r1,0x10; LOAD r2,0x11; SUB r3,r1,r2; STORE 0x12,r3 → D[0x12]=0xFFFD.
- ABS: LOADC r1,0xFF; SUB r2,r0,r1 (r0=0); ABS r3,r2 → RF[3]=0x00FF.
- JMPZ: at addr 4, r5=0, k=0xFE → PC becomes 2. Same instruction with r5=1 → PC becomes 5. Both cases take 3 cycles.
- Illegal opcode and wrap: opcode 0x7 → `illegal`=1 and stays 1, execution continues at the next PC. PC=0xFFFF after fetch wraps to 0x0000.
